// File: rtl/reg_writeback.sv
// reg_writeback
//   Write-side front end of the register file. Single-cycle ALU results and
//   queued multi-cycle (load / multiply) results share one registered write
//   port. Writes to r0 are dropped. When the ALU keeps winning the write slot
//   while multi-cycle results wait, the block switches to a drain mode that
//   stalls the ALU until the queue is empty.
//
//   Optional feature macro: WB_MC_BYPASS_EN
//     When defined, an MC result arriving while the queue is empty and no ALU
//     write is taking the slot goes straight to the output register.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   alu_valid/wr/wd      ALU result (single cycle)
//   alu_stall            ALU must hold its result (drain mode)
//   mc_valid/wr/wd       multi-cycle result offer
//   mc_ready             queue has room
//   rd_chk / hazard      decode query: register has a write pending
//   write / WR / WD      registered register-file write port
module reg_writeback #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_wr,
    input  logic [31:0] alu_wd,
    output logic        alu_stall,
    input  logic        mc_valid,
    input  logic [4:0]  mc_wr,
    input  logic [31:0] mc_wd,
    output logic        mc_ready,
    input  logic [4:0]  rd_chk,
    output logic        hazard,
    output logic        write,
    output logic [4:0]  WR,
    output logic [31:0] WD
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_DRAIN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    starve_q, starve_d;
    logic          write_q, write_d;
    logic [4:0]    wr_q, wr_d;
    logic [31:0]   wd_q, wd_d;

    // Plain flops rather than RAM: every entry is compared against rd_chk.
    logic [36:0]   fifo_mem [DEPTH];
    logic [36:0]   fifo_head;

    logic          fifo_empty;
    logic          alu_wen;
    logic          mc_wen;
    logic          push;
    logic          pop;
    logic          bypass;
    logic [DEPTH-1:0] entry_hit;

    genvar gi;

    assign alu_stall  = (state_q == ST_DRAIN);
    assign mc_ready   = (count_q < CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign fifo_head  = fifo_mem[rd_ptr_q];

    // r0 results are accepted but never produce a write or a queue entry.
    assign alu_wen = alu_valid & ~alu_stall & (alu_wr != 5'd0);
    assign mc_wen  = mc_valid & mc_ready & (mc_wr != 5'd0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_NORMAL;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            write_q  <= 1'b0;
            wr_q     <= '0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            write_q  <= write_d;
            wr_q     <= wr_d;
            wd_q     <= wd_d;
        end
    end

    // Queue storage; stale contents are harmless because validity comes from
    // the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {mc_wr, mc_wd};
        end
    end

    // Next-state: starvation counting and NORMAL/DRAIN transitions
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            ST_NORMAL: begin
                if (fifo_empty || pop) begin
                    starve_d = '0;
                end else if (alu_wen) begin
                    if (starve_q == 8'(STARVE_LIMIT - 1)) begin
                        state_d  = ST_DRAIN;
                        starve_d = '0;
                    end else begin
                        starve_d = starve_q + 8'd1;
                    end
                end
            end
            ST_DRAIN: begin
                starve_d = '0;
                // A same-cycle push keeps us draining; leave only once empty.
                if (count_d == '0) begin
                    state_d = ST_NORMAL;
                end
            end
            default: begin
                state_d  = ST_NORMAL;
                starve_d = '0;
            end
        endcase
    end

    // Output / datapath: choose the write-slot source and queue movement
    always_comb begin
        pop     = 1'b0;
        bypass  = 1'b0;
        write_d = 1'b0;
        wr_d    = wr_q;
        wd_d    = wd_q;
        if (state_q == ST_NORMAL) begin
            if (alu_wen) begin
                write_d = 1'b1;
                wr_d    = alu_wr;
                wd_d    = alu_wd;
            end else if (!fifo_empty) begin
                pop     = 1'b1;
                write_d = 1'b1;
                wr_d    = fifo_head[36:32];
                wd_d    = fifo_head[31:0];
            end
`ifdef WB_MC_BYPASS_EN
            else if (mc_wen) begin
                bypass  = 1'b1;
                write_d = 1'b1;
                wr_d    = mc_wr;
                wd_d    = mc_wd;
            end
`endif
        end else if (!fifo_empty) begin
            pop     = 1'b1;
            write_d = 1'b1;
            wr_d    = fifo_head[36:32];
            wd_d    = fifo_head[31:0];
        end
        push     = mc_wen & ~bypass;
        rd_ptr_d = rd_ptr_q + PW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // An entry is live when its distance from the read pointer is below count.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_hit
            logic [PW-1:0] age;
            assign age           = PW'(gi) - rd_ptr_q;
            assign entry_hit[gi] = (CW'(age) < count_q) &&
                                   (fifo_mem[gi][36:32] == rd_chk);
        end
    endgenerate

    assign hazard = (rd_chk != 5'd0) &&
                    ((|entry_hit) || (write_q && (wr_q == rd_chk)));

    assign write = write_q;
    assign WR    = wr_q;
    assign WD    = wd_q;

endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_wr = '0;
    logic [31:0] alu_wd = '0;
    logic        alu_stall;
    logic        mc_valid = 1'b0;
    logic [4:0]  mc_wr = '0;
    logic [31:0] mc_wd = '0;
    logic        mc_ready;
    logic [4:0]  rd_chk = '0;
    logic        hazard;
    logic        write;
    logic [4:0]  WR;
    logic [31:0] WD;

    always #5 clk = ~clk;

    reg_writeback #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_wr(alu_wr), .alu_wd(alu_wd), .alu_stall(alu_stall),
        .mc_valid(mc_valid), .mc_wr(mc_wr), .mc_wd(mc_wd), .mc_ready(mc_ready),
        .rd_chk(rd_chk), .hazard(hazard),
        .write(write), .WR(WR), .WD(WD)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of pending {reg,data}, a drain flag and a
    // count of consecutive ALU-over-queue wins.
    logic [36:0] m_fifo[$];
    bit          m_drain;
    int          m_starve;
    logic        m_write;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;

    // Combinational outputs sampled mid-cycle, with their model predictions.
    logic obs_stall, obs_ready, obs_hazard;
    logic exp_stall, exp_ready, exp_hazard;

    task automatic model_update(input logic rst, input logic av, input logic [4:0] aw,
                                input logic [31:0] ad, input logic mv,
                                input logic [4:0] mw, input logic [31:0] md);
        int sz;
        bit alu_w, mc_w, popped, byp;
        logic [36:0] head;
        if (rst) begin
            m_fifo.delete();
            m_drain = 0; m_starve = 0;
            m_write = 0; m_wr = '0; m_wd = '0;
            return;
        end
        sz = m_fifo.size();
        alu_w  = av && !m_drain && (aw != 0);
        mc_w   = mv && (sz < DEPTH) && (mw != 0);
        popped = 0; byp = 0;
        m_write = 0;
        if (!m_drain) begin
            if (alu_w) begin
                m_write = 1; m_wr = aw; m_wd = ad;
            end else if (sz > 0) begin
                head = m_fifo.pop_front(); popped = 1;
                m_write = 1; m_wr = head[36:32]; m_wd = head[31:0];
            end
`ifdef WB_MC_BYPASS_EN
            else if (mc_w) begin
                byp = 1; m_write = 1; m_wr = mw; m_wd = md;
            end
`endif
            if (sz == 0 || popped) m_starve = 0;
            else if (alu_w) begin
                m_starve++;
                if (m_starve == LIMIT) begin
                    m_drain = 1; m_starve = 0;
                end
            end
        end else if (sz > 0) begin
            head = m_fifo.pop_front(); popped = 1;
            m_write = 1; m_wr = head[36:32]; m_wd = head[31:0];
        end
        if (mc_w && !byp) m_fifo.push_back({mw, md});
        if (m_drain && m_fifo.size() == 0) begin
            m_drain = 0; m_starve = 0;
        end
    endtask

    // One clock cycle: drive, sample combinational outputs mid-cycle,
    // advance the model, then return 1 time unit after the rising edge.
    task automatic step(input logic rst, input logic av, input logic [4:0] aw,
                        input logic [31:0] ad, input logic mv, input logic [4:0] mw,
                        input logic [31:0] md, input logic [4:0] rc);
        reset = rst; alu_valid = av; alu_wr = aw; alu_wd = ad;
        mc_valid = mv; mc_wr = mw; mc_wd = md; rd_chk = rc;
        @(negedge clk);
        obs_stall = alu_stall; obs_ready = mc_ready; obs_hazard = hazard;
        exp_stall = m_drain;
        exp_ready = (m_fifo.size() < DEPTH);
        exp_hazard = 0;
        if (rc != 0) begin
            foreach (m_fifo[i]) if (m_fifo[i][36:32] == rc) exp_hazard = 1;
            if (m_write && m_wr == rc) exp_hazard = 1;
        end
        model_update(rst, av, aw, ad, mv, mw, md);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if ({write, WR, WD} !== 38'd0) begin
            n_fail++; $display("FAIL reset_regs: got write=%b WR=%0d WD=%h want 0/0/0", write, WR, WD);
        end
        step(0, 0, 0, 0, 0, 0, 0, 5'd5);
        n_tests++;
        if (obs_stall !== 1'b0 || obs_ready !== 1'b1 || obs_hazard !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got stall=%b ready=%b hazard=%b want 0/1/0", obs_stall, obs_ready, obs_hazard);
        end
        n_tests++;
        if (write !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_write: got %b want 0", write);
        end
        $display("[TB] reset: write=%b WR=%0d WD=%h stall=%b ready=%b", write, WR, WD, obs_stall, obs_ready);
    endtask

    task automatic test_alu_r0;
        step(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0);
        n_tests++;
        if ({write, WR, WD} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL alu_write: got %b/%0d/%h want 1/5/deadbeef", write, WR, WD);
        end
        $display("[TB] alu wr=5: write=%b WR=%0d WD=%h", write, WR, WD);
        step(0, 1, 5'd0, 32'h11111111, 0, 0, 0, 5'd5);
        n_tests++;
        if (obs_hazard !== 1'b1) begin
            n_fail++; $display("FAIL alu_out_hazard: got %b want 1", obs_hazard);
        end
        n_tests++;
        if ({write, WR, WD} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL alu_r0: got %b/%0d/%h want 0/5/deadbeef (held)", write, WR, WD);
        end
        $display("[TB] alu wr=0: write=%b WR=%0d WD=%h", write, WR, WD);
    endtask

    task automatic test_mc_latency;
        step(0, 0, 0, 0, 1, 5'd9, 32'h1234, 0);
`ifdef WB_MC_BYPASS_EN
        n_tests++;
        if ({write, WR, WD} !== {1'b1, 5'd9, 32'h1234}) begin
            n_fail++; $display("FAIL mc_bypass_n1: got %b/%0d/%h want 1/9/1234", write, WR, WD);
        end
        step(0, 0, 0, 0, 0, 0, 0, 5'd9);
        n_tests++;
        if (write !== 1'b0) begin
            n_fail++; $display("FAIL mc_bypass_n2: got write=%b want 0", write);
        end
`else
        n_tests++;
        if (write !== 1'b0) begin
            n_fail++; $display("FAIL mc_latency_n1: got write=%b want 0", write);
        end
        step(0, 0, 0, 0, 0, 0, 0, 5'd9);
        n_tests++;
        if (obs_hazard !== 1'b1) begin
            n_fail++; $display("FAIL mc_queued_hazard: got %b want 1", obs_hazard);
        end
        n_tests++;
        if ({write, WR, WD} !== {1'b1, 5'd9, 32'h1234}) begin
            n_fail++; $display("FAIL mc_latency_n2: got %b/%0d/%h want 1/9/1234", write, WR, WD);
        end
`endif
        $display("[TB] mc latency: write=%b WR=%0d WD=%h", write, WR, WD);
    endtask

    // Fill the queue with r1..r4 while the ALU holds the slot every cycle.
    task automatic fill_under_alu;
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 5'(16 + i), $urandom, 1, 5'(i), 32'hA0 + i, 0);
            n_tests++;
            if ({write, WR} !== {1'b1, 5'(16 + i)}) begin
                n_fail++; $display("FAIL fill_alu_wins %0d: got %b/%0d want 1/%0d", i, write, WR, 16 + i);
            end
        end
    endtask

    task automatic test_full_starve;
        int onset;
        fill_under_alu();
        step(0, 1, 5'd21, $urandom, 1, 5'd5, 32'h55, 5'd3);
        n_tests++;
        if (obs_ready !== 1'b0 || obs_hazard !== 1'b1) begin
            n_fail++; $display("FAIL full_ready_haz3: got ready=%b hazard=%b want 0/1", obs_ready, obs_hazard);
        end
        step(0, 1, 5'd22, $urandom, 0, 0, 0, 5'd5);
        n_tests++;
        if (obs_hazard !== 1'b0) begin
            n_fail++; $display("FAIL full_5th_rejected: got hazard(r5)=%b want 0", obs_hazard);
        end
        step(0, 1, 5'd23, $urandom, 0, 0, 0, 5'd7);
        n_tests++;
        if (obs_hazard !== 1'b0) begin
            n_fail++; $display("FAIL full_haz7: got %b want 0", obs_hazard);
        end
        step(0, 1, 5'd24, $urandom, 0, 0, 0, 5'd0);
        n_tests++;
        if (obs_hazard !== 1'b0) begin
            n_fail++; $display("FAIL full_haz0: got %b want 0", obs_hazard);
        end
        // Seven blocked cycles so far; the eighth switches to drain.
        onset = -1;
        for (int k = 0; k < 12; k++) begin
            step(0, 1, 5'd25, $urandom, 0, 0, 0, 0);
            if (obs_stall === 1'b1) begin
                onset = k;
                break;
            end
        end
        n_tests++;
        if (onset != 1) begin
            n_fail++; $display("FAIL stall_onset: got step %0d want 1", onset);
        end
        n_tests++;
        if ({write, WR, WD} !== {1'b1, 5'd1, 32'hA1}) begin
            n_fail++; $display("FAIL drain_r1: got %b/%0d/%h want 1/1/a1", write, WR, WD);
        end
        $display("[TB] drain pop: WR=%0d WD=%h", WR, WD);
        for (int j = 2; j <= 4; j++) begin
            step(0, 1, 5'd26, $urandom, 0, 0, 0, 0);
            n_tests++;
            if (obs_stall !== 1'b1 || {write, WR, WD} !== {1'b1, 5'(j), 32'hA0 + j}) begin
                n_fail++; $display("FAIL drain_r%0d: got stall=%b %b/%0d/%h want 1 1/%0d/%h", j, obs_stall, write, WR, WD, j, 32'hA0 + j);
            end
            $display("[TB] drain pop: WR=%0d WD=%h", WR, WD);
        end
        step(0, 1, 5'd30, 32'hCAFE0030, 0, 0, 0, 0);
        n_tests++;
        if (obs_stall !== 1'b0 || {write, WR, WD} !== {1'b1, 5'd30, 32'hCAFE0030}) begin
            n_fail++; $display("FAIL drain_exit: got stall=%b %b/%0d/%h want 0 1/30/cafe0030", obs_stall, write, WR, WD);
        end
    endtask

    task automatic test_reset_mid_drain;
        int seen;
        fill_under_alu();
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            step(0, 1, 5'd27, $urandom, 0, 0, 0, 0);
            if (obs_stall === 1'b1) seen = 1;
        end
        n_tests++;
        if (seen != 1 || WR !== 5'd1) begin
            n_fail++; $display("FAIL middrain_enter: got seen=%0d WR=%0d want 1/1", seen, WR);
        end
        step(0, 1, 5'd27, $urandom, 0, 0, 0, 0);
        step(1, 1, 5'd28, $urandom, 1, 5'd6, 32'h66, 0);
        n_tests++;
        if (write !== 1'b0) begin
            n_fail++; $display("FAIL middrain_reset_write: got %b want 0", write);
        end
        step(0, 0, 0, 0, 0, 0, 0, 5'd3);
        n_tests++;
        if (obs_stall !== 1'b0 || obs_ready !== 1'b1 || obs_hazard !== 1'b0) begin
            n_fail++; $display("FAIL middrain_flags: got stall=%b ready=%b hazard=%b want 0/1/0", obs_stall, obs_ready, obs_hazard);
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, 5'd4);
            n_tests++;
            if (write !== 1'b0 || obs_hazard !== 1'b0) begin
                n_fail++; $display("FAIL middrain_no_write %0d: got write=%b hazard=%b want 0/0", k, write, obs_hazard);
            end
        end
        $display("[TB] reset mid-drain: write=%b stall=%b", write, obs_stall);
    endtask

    task automatic test_random;
        logic rst, av, mv;
        logic [4:0] aw, mw, rc;
        logic [31:0] ad, md;
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            av  = ($urandom_range(0, 9) < 7);
            mv  = ($urandom_range(0, 9) < 5);
            aw  = 5'($urandom_range(0, 7));
            mw  = 5'($urandom_range(0, 7));
            rc  = 5'($urandom_range(0, 7));
            ad  = $urandom;
            md  = $urandom;
            step(rst, av, aw, ad, mv, mw, md, rc);
            n_tests++;
            if ({obs_stall, obs_ready, obs_hazard} !== {exp_stall, exp_ready, exp_hazard}) begin
                n_fail++; $display("FAIL rand_flags cyc %0d: got stall/ready/haz=%b%b%b want %b%b%b", c, obs_stall, obs_ready, obs_hazard, exp_stall, exp_ready, exp_hazard);
            end
            n_tests++;
            if ({write, WR, WD} !== {m_write, m_wr, m_wd}) begin
                n_fail++; $display("FAIL rand_port cyc %0d: got %b/%0d/%h want %b/%0d/%h", c, write, WR, WD, m_write, m_wr, m_wd);
            end
        end
        $display("[TB] random: 1500 cycles checked");
    endtask

    initial begin
        test_reset();
        test_alu_r0();
        test_mc_latency();
        test_full_starve();
        test_reset_mid_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
